// File: rtl/viterbi_frame_ctrl.sv
// Frame controller for a Viterbi BER loop: feeds an LFSR payload and zero tail to the encoder,
// optionally flags a channel error burst, and counts decoded-bit mismatches against a ref LFSR.
module viterbi_frame_ctrl #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned TAIL_LEN  = 6,
    parameter int unsigned DEC_LAT   = 32,
    parameter int unsigned BURST_LEN = 4,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        inj_en_i,
    input  logic [15:0] burst_start_i,
    input  logic        dec_bit_i,
    output logic        enc_bit_o,
    output logic        enc_en_o,
    output logic [1:0]  inj_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] err_count_o,
    output logic [15:0] frame_ct_o
);

    typedef enum logic [2:0] {StIdle, StPayload, StTail, StDrain, StDone} state_t;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // 17-bit window compare so burst_start + BURST_LEN never wraps back into the frame.
    function automatic logic burst_hit(input logic en, input logic [15:0] bs,
                                       input logic [15:0] idx);
        logic [16:0] w_lo;
        logic [16:0] w_hi;
        logic [16:0] w_ix;
        w_lo = {1'b0, bs};
        w_hi = w_lo + 17'(BURST_LEN);
        w_ix = {1'b0, idx};
        return en && (w_ix >= w_lo) && (w_ix < w_hi);
    endfunction

    state_t             r_state;
    logic [15:0]        r_cnt;
    logic [15:0]        r_tx;
    logic [15:0]        r_ref;
    logic [DEC_LAT-1:0] r_pv;
    logic               r_inj_en;
    logic [15:0]        r_burst;
    logic [15:0]        r_err;
    logic [15:0]        r_fc;
    logic               r_enc_bit;
    logic               r_enc_en;
    logic [1:0]         r_inj;
    logic               r_busy;
    logic               r_done;

    logic               w_pay;
    logic               w_cmp;
    logic               w_mism;
    logic               w_pending;
    logic [DEC_LAT-1:0] w_pv_shift;
    logic [DEC_LAT-1:0] w_pv_nxt;
    logic [15:0]        w_tx_nxt;
    logic [15:0]        w_idx_nxt;

    always_comb begin
        w_pay       = (r_state == StPayload);
        w_pv_shift  = r_pv << 1;
        w_pv_nxt    = w_pv_shift;
        w_pv_nxt[0] = w_pay;
        // Flags still waiting after this cycle's compare; the incoming flag is 0 outside PAYLOAD.
        w_pending   = |w_pv_shift;
        w_cmp       = r_pv[DEC_LAT-1];
        w_mism      = w_cmp && (dec_bit_i != r_ref[0]);
        w_tx_nxt    = lfsr_adv(r_tx);
        w_idx_nxt   = r_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_tx      <= SEED;
            r_ref     <= SEED;
            r_pv      <= '0;
            r_inj_en  <= 1'b0;
            r_burst   <= '0;
            r_err     <= '0;
            r_fc      <= '0;
            r_enc_bit <= 1'b0;
            r_enc_en  <= 1'b0;
            r_inj     <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_pv   <= w_pv_nxt;
            r_done <= 1'b0;
            if (w_cmp) begin
                r_ref <= lfsr_adv(r_ref);
            end
            if (w_mism && (r_err != 16'hFFFF)) begin
                r_err <= r_err + 16'd1;
            end
            unique case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_state   <= StPayload;
                        r_cnt     <= '0;
                        r_tx      <= SEED;
                        r_ref     <= SEED;
                        r_err     <= '0;
                        r_inj_en  <= inj_en_i;
                        r_burst   <= burst_start_i;
                        r_busy    <= 1'b1;
                        r_enc_en  <= 1'b1;
                        r_enc_bit <= SEED[0];
                        r_inj     <= burst_hit(inj_en_i, burst_start_i, 16'd0) ? 2'b10 : 2'b00;
                    end
                end
                StPayload: begin
                    r_tx <= w_tx_nxt;
                    if (r_cnt == 16'(FRAME_LEN - 1)) begin
                        r_cnt     <= '0;
                        r_enc_bit <= 1'b0;
                        r_inj     <= 2'b00;
                        if (TAIL_LEN > 0) begin
                            r_state <= StTail;
                        end else begin
                            r_state  <= StDrain;
                            r_enc_en <= 1'b0;
                        end
                    end else begin
                        r_cnt     <= w_idx_nxt;
                        r_enc_bit <= w_tx_nxt[0];
                        r_inj     <= burst_hit(r_inj_en, r_burst, w_idx_nxt) ? 2'b10 : 2'b00;
                    end
                end
                StTail: begin
                    r_cnt <= w_idx_nxt;
                    if (r_cnt == 16'(TAIL_LEN - 1)) begin
                        r_state  <= StDrain;
                        r_enc_en <= 1'b0;
                    end
                end
                StDrain: begin
                    if (!w_pending) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                        r_fc    <= r_fc + 16'd1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign enc_bit_o   = r_enc_bit;
    assign enc_en_o    = r_enc_en;
    assign inj_o       = r_inj;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_count_o = r_err;
    assign frame_ct_o  = r_fc;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl: per-cycle expected outputs are queued at frame start
// and compared as the frame runs; the decoder is modelled as a delayed loopback of enc_bit_o.
module tb_viterbi_frame_ctrl;

    localparam int F  = 256;
    localparam int T  = 6;
    localparam int L  = 32;
    localparam int BL = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int ModeNorm = 0;
    localparam int ModeInv  = 1;
    localparam int ModeFlip = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        inj_en_i;
    logic [15:0] burst_start_i;
    logic        dec_bit_i;
    logic        enc_bit_o;
    logic        enc_en_o;
    logic [1:0]  inj_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] err_count_o;
    logic [15:0] frame_ct_o;

    logic        start_b;
    logic        dec_b;
    logic        enc_bit_b;
    logic        enc_en_b;
    logic [1:0]  inj_b;
    logic        busy_b;
    logic        done_b;
    logic [15:0] err_b;
    logic [15:0] fc_b;

    typedef struct {
        int          cyc;
        logic        busy;
        logic        en;
        logic        bitv;
        logic        done;
        logic [1:0]  inj;
        logic [15:0] err;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   mode     = ModeNorm;
    int   k0       = 0;
    int   fc_model = 0;
    logic hist[64];
    logic hist_b[64];

    always #5 clk = ~clk;

    viterbi_frame_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .inj_en_i     (inj_en_i),
        .burst_start_i(burst_start_i),
        .dec_bit_i    (dec_bit_i),
        .enc_bit_o    (enc_bit_o),
        .enc_en_o     (enc_en_o),
        .inj_o        (inj_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_count_o  (err_count_o),
        .frame_ct_o   (frame_ct_o)
    );

    viterbi_frame_ctrl #(.DEC_LAT(3)) u_dut_lat3 (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_b),
        .inj_en_i     (1'b0),
        .burst_start_i(16'd0),
        .dec_bit_i    (dec_b),
        .enc_bit_o    (enc_bit_b),
        .enc_en_o     (enc_en_b),
        .inj_o        (inj_b),
        .busy_o       (busy_b),
        .done_o       (done_b),
        .err_count_o  (err_b),
        .frame_ct_o   (fc_b)
    );

    // Advance one clock, sample just after the edge, drive loopback, pop due scoreboard entries.
    task automatic tick();
        exp_t e;
        logic b;
        int   src;
        @(posedge clk);
        #1;
        cyc++;
        hist[cyc % 64]   = enc_bit_o;
        hist_b[cyc % 64] = enc_bit_b;
        if (cyc >= L) begin
            src = cyc - L;
            b   = hist[src % 64];
            if (mode == ModeInv) b = ~b;
            if (mode == ModeFlip && (src - k0 - 1) == 100) b = ~b;
            dec_bit_i = b;
        end
        if (cyc >= 3) dec_b = hist_b[(cyc - 3) % 64];
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc || busy_o !== e.busy || enc_en_o !== e.en || enc_bit_o !== e.bitv ||
                done_o !== e.done || inj_o !== e.inj || err_count_o !== e.err ||
                frame_ct_o !== e.fc) begin
                n_errors++;
                $display("FAIL sb_cycle cyc=%0d(due %0d) got busy=%b en=%b bit=%b done=%b inj=%b err=%0d fc=%0d want busy=%b en=%b bit=%b done=%b inj=%b err=%0d fc=%0d",
                         cyc, e.cyc, busy_o, enc_en_o, enc_bit_o, done_o, inj_o, err_count_o,
                         frame_ct_o, e.busy, e.en, e.bitv, e.done, e.inj, e.err, e.fc);
            end
        end
    endtask

    task automatic push_idle(input int c, input int err, input int fc);
        exp_t e;
        e.cyc = c; e.busy = 1'b0; e.en = 1'b0; e.bitv = 1'b0; e.done = 1'b0;
        e.inj = 2'b00; e.err = 16'(err); e.fc = 16'(fc);
        sb.push_back(e);
    endtask

    // Expected outputs for cycles c0+1 .. c0+F+L+1 (DONE), plus one trailing IDLE cycle.
    task automatic push_frame(input int c0, input logic ien, input int bs, input logic with_idle);
        exp_t        e;
        logic [15:0] l = SEED;
        int          errs = 0;
        int          idx;
        for (int r = 1; r <= F + L + 1 + (with_idle ? 1 : 0); r++) begin
            e.cyc  = c0 + r;
            e.busy = (r <= F + L + 1);
            e.en   = (r <= F + T);
            e.bitv = 1'b0;
            if (r <= F) begin
                e.bitv = l[0];
                l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
            end
            e.inj  = (ien && r <= F && (r - 1) >= bs && (r - 1) < bs + BL) ? 2'b10 : 2'b00;
            e.done = (r == F + L + 1);
            if (r == F + L + 1) fc_model = (fc_model + 1) % 65536;
            e.fc   = 16'(fc_model);
            e.err  = 16'(errs);
            if (r >= L + 1 && r <= F + L) begin
                idx = r - 1 - L;
                if (mode == ModeInv || (mode == ModeFlip && idx == 100)) errs++;
            end
            sb.push_back(e);
        end
    endtask

    task automatic start_frame(input logic ien, input int bs);
        k0            = cyc;
        inj_en_i      = ien;
        burst_start_i = 16'(bs);
        push_frame(cyc, ien, bs, 1'b1);
        start_i = 1'b1;
        tick();
        start_i  = 1'b0;
        inj_en_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b1; inj_en_i = 1'b1; burst_start_i = 16'd0;
        tick();
        for (int c = 2; c <= 6; c++) push_idle(c, 0, 0);
        repeat (3) tick();
        rst = 1'b0; start_i = 1'b0; inj_en_i = 1'b0;
        tick();
        n_checks++;
        if ({enc_bit_o, enc_en_o, inj_o, busy_o, done_o} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_outputs got %b want 000000",
                     {enc_bit_o, enc_en_o, inj_o, busy_o, done_o});
        end
        tick();
        n_checks++;
        if (err_count_o !== 16'd0 || frame_ct_o !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_counts got err=%0d fc=%0d want 0 0", err_count_o, frame_ct_o);
        end
        fc_model = 0;
    endtask

    task automatic test_frame(input int md, input logic ien, input int bs, input int exp_err);
        mode = md;
        start_frame(ien, bs);
        for (int n = 0; n < 400 && sb.size() > 0; n++) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL frame_timeout mode=%0d got %0d pending want 0", md, sb.size());
            sb.delete();
        end
        n_checks++;
        if (err_count_o !== 16'(exp_err) || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_err_hold mode=%0d bs=%0d got err=%0d busy=%b want err=%0d busy=0",
                     md, bs, err_count_o, busy_o, exp_err);
        end
        n_checks++;
        if (frame_ct_o !== 16'(fc_model)) begin
            n_errors++;
            $display("FAIL frame_count got %0d want %0d", frame_ct_o, fc_model);
        end
    endtask

    task automatic test_loopback();
        test_frame(ModeNorm, 1'b0, 0, 0);
    endtask

    task automatic test_inverted();
        test_frame(ModeInv, 1'b0, 0, 256);
    endtask

    task automatic test_single_flip();
        test_frame(ModeFlip, 1'b0, 0, 1);
    endtask

    task automatic test_burst();
        test_frame(ModeNorm, 1'b1, 10, 0);
        test_frame(ModeNorm, 1'b1, 254, 0);
        test_frame(ModeNorm, 1'b1, 65534, 0);
    endtask

    task automatic test_reset_mid();
        int c0;
        mode = ModeNorm;
        c0 = cyc;
        start_frame(1'b1, 20);
        while (cyc < c0 + 100) tick();
        rst = 1'b1;
        sb.delete();
        fc_model = 0;
        push_idle(c0 + 101, 0, 0);
        push_idle(c0 + 102, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy_o !== 1'b0 || frame_ct_o !== 16'd0 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL reset_mid got busy=%b fc=%0d pending=%0d want 0 0 0",
                     busy_o, frame_ct_o, sb.size());
        end
        test_frame(ModeNorm, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int c0;
        int dones = 0;
        int adj = 0;
        logic prev_done = 1'b0;
        mode = ModeNorm;
        c0 = cyc;
        k0 = c0;
        inj_en_i = 1'b0;
        push_frame(c0, 1'b0, 0, 1'b1);
        push_frame(c0 + F + L + 2, 1'b0, 0, 1'b1);
        start_i = 1'b1;
        for (int n = 0; n < 1000 && sb.size() > 0; n++) begin
            tick();
            if (cyc == c0 + F + L + 12) start_i = 1'b0;
            if (done_o) dones++;
            if (done_o && prev_done) adj++;
            prev_done = done_o;
        end
        start_i = 1'b0;
        n_checks++;
        if (sb.size() != 0 || dones != 2 || adj != 0) begin
            n_errors++;
            $display("FAIL back_to_back got pending=%0d dones=%0d adjacent=%0d want 0 2 0",
                     sb.size(), dones, adj);
            sb.delete();
        end
        n_checks++;
        if (frame_ct_o !== 16'(fc_model) || err_count_o !== 16'd0) begin
            n_errors++;
            $display("FAIL back_to_back_counts got fc=%0d err=%0d want %0d 0",
                     frame_ct_o, err_count_o, fc_model);
        end
    endtask

    task automatic test_dec_lat3();
        int c0;
        int done_at = -1;
        int en_cnt = 0;
        int inj_bad = 0;
        c0 = cyc;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int n = 0; n < 400 && done_at < 0; n++) begin
            if (enc_en_b) en_cnt++;
            if (inj_b !== 2'b00) inj_bad++;
            if (done_b) done_at = cyc - c0;
            else tick();
        end
        n_checks++;
        if (done_at != F + T + 2) begin
            n_errors++;
            $display("FAIL lat3_done_cycle got k+%0d want k+%0d", done_at, F + T + 2);
        end
        n_checks++;
        if (err_b !== 16'd0 || fc_b !== 16'd1 || en_cnt != F + T || inj_bad != 0) begin
            n_errors++;
            $display("FAIL lat3_frame got err=%0d fc=%0d en_cycles=%0d inj_bad=%0d want 0 1 %0d 0",
                     err_b, fc_b, en_cnt, inj_bad, F + T);
        end
        tick();
        n_checks++;
        if (busy_b !== 1'b0 || done_b !== 1'b0) begin
            n_errors++;
            $display("FAIL lat3_idle got busy=%b done=%b want 0 0", busy_b, done_b);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            hist[i]   = 1'b0;
            hist_b[i] = 1'b0;
        end
        rst = 1'b1; start_i = 1'b0; inj_en_i = 1'b0; burst_start_i = 16'd0;
        dec_bit_i = 1'b0; start_b = 1'b0; dec_b = 1'b0;
        test_reset();
        test_loopback();
        test_inverted();
        test_single_flip();
        test_burst();
        test_reset_mid();
        test_back_to_back();
        test_dec_lat3();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
